// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite scatter-gather descriptor memory:
// response codes, FSM state encodings and descriptor field byte offsets.
package axil_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_RESP = 1'b1
   } wr_state_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_DATA = 1'b1
   } rd_state_t;

   // Byte offsets of the descriptor fields relative to a descriptor start
   localparam logic [7:0] NXDS_OFF = 8'h00;
   localparam logic [7:0] BADD_OFF = 8'h08;
   localparam logic [7:0] CTRL_OFF = 8'h18;
   localparam logic [7:0] STAT_OFF = 8'h1C;

endpackage

// File: rtl/axil_bytewr_ram.sv
// DEPTH x 32 storage: one byte-enabled write port and one registered read port.
// Read-during-write to the same word returns the old contents.
module axil_bytewr_ram #(
   parameter int DEPTH = 64,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [IW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [3:0]    wstrb_i,
   input  logic          re_i,
   input  logic [IW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // Storage is deliberately left out of reset so committed writes survive it
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i && wstrb_i[b]) begin
            mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_sg_desc_mem.sv
// AXI4-Lite responder over DEPTH words of SG descriptor storage at BASE_ADDR.
// Define AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_sg_desc_mem
   import axil_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 32,
   parameter int          DEPTH      = 64,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0100
) (
   input  logic                    S_AXI_aclk,
   input  logic                    S_AXI_aresetn,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
   input  logic [2:0]              S_AXI_awprot,
   input  logic                    S_AXI_awvalid,
   output logic                    S_AXI_awready,
   input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
   input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
   input  logic                    S_AXI_wvalid,
   output logic                    S_AXI_wready,
   output logic [1:0]              S_AXI_bresp,
   output logic                    S_AXI_bvalid,
   input  logic                    S_AXI_bready,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
   input  logic [2:0]              S_AXI_arprot,
   input  logic                    S_AXI_arvalid,
   output logic                    S_AXI_arready,
   output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
   output logic [1:0]              S_AXI_rresp,
   output logic                    S_AXI_rvalid,
   input  logic                    S_AXI_rready
);

   localparam int                    IW   = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4 * DEPTH);
`ifdef AXIL_SLVERR_EN
   localparam resp_t OOR_RESP = SLVERR;
`else
   localparam resp_t OOR_RESP = OKAY;
`endif

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return (a >= BASE) && ((a - BASE) < SPAN);
   endfunction

   function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
      return IW'((a - BASE) >> 2);
   endfunction

   wr_state_t               wr_state_q, wr_state_d;
   logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   resp_t                   bresp_q, bresp_d;
   logic                    aw_hs, w_hs, ram_we;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH/8-1:0] wr_strb;

   rd_state_t rd_state_q, rd_state_d;
   resp_t     rresp_q, rresp_d;
   logic      rd_oor_q, rd_oor_d;
   logic      ar_hs;
   logic [31:0] ram_rdata;

   logic unused_prot;
   assign unused_prot = ^{S_AXI_awprot, S_AXI_arprot};

   // Readies are gated by the raw reset so they read 0 while it is held low
   assign S_AXI_awready = S_AXI_aresetn && !aw_held_q && (wr_state_q == WR_IDLE);
   assign S_AXI_wready  = S_AXI_aresetn && !w_held_q && (wr_state_q == WR_IDLE);
   assign S_AXI_bvalid  = (wr_state_q == WR_RESP);
   assign S_AXI_bresp   = bresp_q;
   assign aw_hs         = S_AXI_awvalid && S_AXI_awready;
   assign w_hs          = S_AXI_wvalid && S_AXI_wready;
   assign wr_addr       = aw_held_q ? awaddr_q : S_AXI_awaddr;
   assign wr_data       = w_held_q ? wdata_q : S_AXI_wdata;
   assign wr_strb       = w_held_q ? wstrb_q : S_AXI_wstrb;

   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bresp_d    = bresp_q;
      ram_we     = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
               ram_we     = in_range(wr_addr);
               bresp_d    = in_range(wr_addr) ? OKAY : OOR_RESP;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               wr_state_d = WR_RESP;
            end else begin
               if (aw_hs) begin
                  aw_held_d = 1'b1;
                  awaddr_d  = S_AXI_awaddr;
               end
               if (w_hs) begin
                  w_held_d = 1'b1;
                  wdata_d  = S_AXI_wdata;
                  wstrb_d  = S_AXI_wstrb;
               end
            end
         end
         WR_RESP: if (S_AXI_bready) wr_state_d = WR_IDLE;
         default: wr_state_d = WR_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_aclk) begin
      if (!S_AXI_aresetn) begin
         wr_state_q <= WR_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
      end
   end

   assign S_AXI_arready = S_AXI_aresetn && (rd_state_q == RD_IDLE);
   assign S_AXI_rvalid  = (rd_state_q == RD_DATA);
   assign S_AXI_rresp   = rresp_q;
   assign S_AXI_rdata   = rd_oor_q ? '0 : DATA_WIDTH'(ram_rdata);
   assign ar_hs         = S_AXI_arvalid && S_AXI_arready;

   always_comb begin
      rd_state_d = rd_state_q;
      rresp_d    = rresp_q;
      rd_oor_d   = rd_oor_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (ar_hs) begin
               rd_oor_d   = !in_range(S_AXI_araddr);
               rresp_d    = in_range(S_AXI_araddr) ? OKAY : OOR_RESP;
               rd_state_d = RD_DATA;
            end
         end
         RD_DATA: if (S_AXI_rready) rd_state_d = RD_IDLE;
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_aclk) begin
      if (!S_AXI_aresetn) begin
         rd_state_q <= RD_IDLE;
         rresp_q    <= OKAY;
         rd_oor_q   <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         rresp_q    <= rresp_d;
         rd_oor_q   <= rd_oor_d;
      end
   end

   axil_bytewr_ram #(
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_ram (
      .clk_i   (S_AXI_aclk),
      .rst_ni  (S_AXI_aresetn),
      .we_i    (ram_we),
      .waddr_i (word_idx(wr_addr)),
      .wdata_i (32'(wr_data)),
      .wstrb_i (4'(wr_strb)),
      .re_i    (ar_hs),
      .raddr_i (word_idx(S_AXI_araddr)),
      .rdata_o (ram_rdata)
   );

endmodule

// File: tb/tb_axil_sg_desc_mem.sv
// Bench for axil_sg_desc_mem: directed vector table, multi-cycle handshake
// sequences and randomized traffic against an array-based memory model.
module tb_axil_sg_desc_mem;
   import axil_pkg::*;

`ifdef AXIL_SLVERR_EN
   localparam logic [1:0] OOR_EXP = 2'b10;
`else
   localparam logic [1:0] OOR_EXP = 2'b00;
`endif

   logic        clk = 1'b0;
   logic        aresetn;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] model_mem [64];

   always #5 clk = ~clk;

   axil_sg_desc_mem dut (
      .S_AXI_aclk    (clk),
      .S_AXI_aresetn (aresetn),
      .S_AXI_awaddr  (awaddr),
      .S_AXI_awprot  (awprot),
      .S_AXI_awvalid (awvalid),
      .S_AXI_awready (awready),
      .S_AXI_wdata   (wdata),
      .S_AXI_wstrb   (wstrb),
      .S_AXI_wvalid  (wvalid),
      .S_AXI_wready  (wready),
      .S_AXI_bresp   (bresp),
      .S_AXI_bvalid  (bvalid),
      .S_AXI_bready  (bready),
      .S_AXI_araddr  (araddr),
      .S_AXI_arprot  (arprot),
      .S_AXI_arvalid (arvalid),
      .S_AXI_arready (arready),
      .S_AXI_rdata   (rdata),
      .S_AXI_rresp   (rresp),
      .S_AXI_rvalid  (rvalid),
      .S_AXI_rready  (rready)
   );

   typedef struct {
      logic        is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic w, input logic [31:0] a, d,
                               input logic [3:0] s, input logic [31:0] ed,
                               input logic [1:0] er);
      vec_t v;
      v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.exp_data = ed; v.exp_resp = er;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic model_in_range(input logic [31:0] a);
      return (a >= 32'h100) && (a < 32'h200);
   endfunction

   function automatic int model_idx(input logic [31:0] a);
      return int'((a - 32'h100) >> 2);
   endfunction

   function automatic void model_write(input logic [31:0] a, d, input logic [3:0] s);
      if (model_in_range(a))
         for (int b = 0; b < 4; b++)
            if (s[b]) model_mem[model_idx(a)][8*b +: 8] = d[8*b +: 8];
   endfunction

   task automatic axi_write(input logic [31:0] a, d, input logic [3:0] s, output logic [1:0] resp);
      int   budget;
      logic aw_d, w_d;
      aw_d = 1'b0; w_d = 1'b0; budget = 0;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      while (!(aw_d && w_d) && budget < 50) begin
         if (awvalid && awready) aw_d = 1'b1;
         if (wvalid && wready) w_d = 1'b1;
         tick();
         if (aw_d) awvalid = 1'b0;
         if (w_d) wvalid = 1'b0;
         budget++;
      end
      budget = 0;
      while (!bvalid && budget < 50) begin
         tick();
         budget++;
      end
      if (!bvalid) check("wr_bvalid_timeout", 32'(bvalid), 32'd1);
      resp = bresp;
      tick();
      bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int budget;
      budget = 0;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      while (!arready && budget < 50) begin
         tick();
         budget++;
      end
      tick();
      arvalid = 1'b0;
      budget = 0;
      while (!rvalid && budget < 50) begin
         tick();
         budget++;
      end
      if (!rvalid) check("rd_rvalid_timeout", 32'(rvalid), 32'd1);
      d = rdata; resp = rresp;
      tick();
      rready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, a, old;
      logic [1:0]  r;
      logic [3:0]  s;

      aresetn = 1'b0; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
      wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_bvalid", 32'(bvalid), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      aresetn = 1'b1;
      #1;
      check("post_rst_awready", 32'(awready), 32'd1);
      check("post_rst_wready", 32'(wready), 32'd1);
      check("post_rst_arready", 32'(arready), 32'd1);
      check("post_rst_rdata", rdata, 32'd0);
      check("post_rst_bresp", 32'(bresp), 32'd0);
      check("post_rst_rresp", 32'(rresp), 32'd0);
      tick();

      // Directed vector table
      vecs.push_back(mk(1, 32'h100 + 32'(NXDS_OFF), 32'h0000_0140, 4'hF, 32'h0, 2'b00));
      vecs.push_back(mk(0, 32'h100, 32'h0, 4'h0, 32'h0000_0140, 2'b00));
      vecs.push_back(mk(1, 32'h100 + 32'(BADD_OFF), 32'h1122_3344, 4'hF, 32'h0, 2'b00));
      vecs.push_back(mk(1, 32'h108, 32'hDEAD_BEEF, 4'b0011, 32'h0, 2'b00));
      vecs.push_back(mk(0, 32'h108, 32'h0, 4'h0, 32'h1122_BEEF, 2'b00));
      vecs.push_back(mk(1, 32'h10C, 32'h0102_0304, 4'hF, 32'h0, 2'b00));
      vecs.push_back(mk(1, 32'h10C, 32'hCAFE_F00D, 4'h0, 32'h0, 2'b00));
      vecs.push_back(mk(0, 32'h10C, 32'h0, 4'h0, 32'h0102_0304, 2'b00));
      vecs.push_back(mk(1, 32'h100 + 32'(CTRL_OFF), 32'h8000_0010, 4'b1100, 32'h0, 2'b00));
      vecs.push_back(mk(1, 32'h200, 32'h5555_5555, 4'hF, 32'h0, OOR_EXP));
      vecs.push_back(mk(1, 32'h0FC, 32'h6666_6666, 4'hF, 32'h0, OOR_EXP));
      vecs.push_back(mk(0, 32'h200, 32'h0, 4'h0, 32'h0, OOR_EXP));
      vecs.push_back(mk(0, 32'h103, 32'h0, 4'h0, 32'h0000_0140, 2'b00));
      vecs.push_back(mk(1, 32'h1FC, 32'hA5A5_5A5A, 4'hF, 32'h0, 2'b00));
      vecs.push_back(mk(0, 32'h1FC, 32'h0, 4'h0, 32'hA5A5_5A5A, 2'b00));
      vecs.push_back(mk(1, 32'h100 + 32'(STAT_OFF), 32'h0000_00FF, 4'b0001, 32'h0, 2'b00));
      foreach (vecs[i]) begin
         if (vecs[i].is_wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
            check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
         end else begin
            axi_read(vecs[i].addr, d, r);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
         end
      end

      // Fill all words so the model is fully defined
      for (int i = 0; i < 64; i++) begin
         d = $urandom;
         axi_write(32'h100 + 32'(4 * i), d, 4'hF, r);
         model_write(32'h100 + 32'(4 * i), d, 4'hF);
         check("fill_bresp", 32'(r), 32'd0);
      end

      // AW alone, W three cycles later
      awaddr = 32'h110; awvalid = 1'b1; bready = 1'b1;
      check("seq3_awready_c0", 32'(awready), 32'd1);
      tick();
      awvalid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         check($sformatf("seq3_awready_c%0d", c), 32'(awready), 32'd0);
         check($sformatf("seq3_bvalid_c%0d", c), 32'(bvalid), 32'd0);
         if (c < 3) tick();
      end
      wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
      check("seq3_wready_c3", 32'(wready), 32'd1);
      tick();
      wvalid = 1'b0;
      model_write(32'h110, 32'h0BAD_F00D, 4'hF);
      check("seq3_bvalid_c4", 32'(bvalid), 32'd1);
      tick();
      bready = 1'b0;
      check("seq3_bvalid_done", 32'(bvalid), 32'd0);
      check("seq3_awready_back", 32'(awready), 32'd1);

      // bready held low: response and back-pressure must hold
      awaddr = 32'h200; awvalid = 1'b1; wdata = 32'h1234_5678; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         check("seq4_bvalid_hold", 32'(bvalid), 32'd1);
         check("seq4_bresp_hold", 32'(bresp), 32'(OOR_EXP));
         check("seq4_awready_low", 32'(awready), 32'd0);
         check("seq4_wready_low", 32'(wready), 32'd0);
         tick();
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check("seq4_bvalid_done", 32'(bvalid), 32'd0);

      // Read and write to the same word on the same edge: old data returned
      old = model_mem[model_idx(32'h120)];
      awaddr = 32'h120; awvalid = 1'b1; wdata = ~old; wstrb = 4'hF; wvalid = 1'b1;
      araddr = 32'h120; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      model_write(32'h120, ~old, 4'hF);
      check("rw_same_rvalid", 32'(rvalid), 32'd1);
      check("rw_same_bvalid", 32'(bvalid), 32'd1);
      check("rw_same_old_data", rdata, old);
      tick();
      bready = 1'b0; rready = 1'b0;
      axi_read(32'h120, d, r);
      check("rw_same_new_data", d, ~old);

      // Reset while a read response is pending
      araddr = 32'h104; arvalid = 1'b1; rready = 1'b0;
      tick();
      arvalid = 1'b0;
      check("seq6_rvalid_pending", 32'(rvalid), 32'd1);
      aresetn = 1'b0;
      tick();
      check("seq6_rvalid_dropped", 32'(rvalid), 32'd0);
      check("seq6_arready_in_rst", 32'(arready), 32'd0);
      aresetn = 1'b1;
      #1;
      check("seq6_arready_after", 32'(arready), 32'd1);
      check("seq6_rdata_cleared", rdata, 32'd0);
      tick();
      axi_read(32'h110, d, r);
      check("seq6_mem_kept", d, model_mem[model_idx(32'h110)]);

      // Randomized traffic against the model
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) < 8) a = 32'h100 + 32'($urandom_range(0, 255));
         else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 255));
         else a = 32'h200 + 32'($urandom_range(0, 4095));
         if ($urandom_range(0, 1) == 0) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, r);
            model_write(a, d, s);
            check("rand_bresp", 32'(r), model_in_range(a) ? 32'd0 : 32'(OOR_EXP));
         end else begin
            axi_read(a, d, r);
            check("rand_rdata", d, model_in_range(a) ? model_mem[model_idx(a)] : 32'd0);
            check("rand_rresp", 32'(r), model_in_range(a) ? 32'd0 : 32'(OOR_EXP));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
